// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared helpers and parameter-check macro for rom_nport_stream and rom_stream_fifo
`ifndef ROM_STREAM_PKG_MACROS
`define ROM_STREAM_PKG_MACROS
`define ROM_STREAM_CHECK(lbl, cond) \
  if (!(cond)) begin : lbl \
    $error("rom_nport_stream: parameter check failed"); \
  end
`endif

package rom_stream_pkg;
  function automatic int rom_latency(input int reg_addr);
    return (reg_addr != 0) ? 2 : 1;
  endfunction
  function automatic int cnt_width(input int fifo_depth);
    return $clog2(fifo_depth + 1);
  endfunction
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction
endpackage

// File: rtl/rom_stream_fifo.sv
// rom_stream_fifo: show-ahead FIFO (wr_en/din push, rd_en pops when valid, dout is the head or 0 when empty)
module rom_stream_fifo import rom_stream_pkg::*; #(
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] din,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] dout,
  output logic              valid
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = cnt_width(FIFO_DEPTH);
  `ROM_STREAM_CHECK(g_chk_depth, FIFO_DEPTH >= 2 && is_pow2(FIFO_DEPTH))
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;
  logic              pop;
  assign valid = cnt != '0;
  assign pop   = rd_en & valid;
  assign dout  = valid ? mem[rp] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(wr_en) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= din;
endmodule

// File: rtl/rom_nport_stream.sv
// rom_nport_stream: N-channel lookup ROM with valid/ready per channel, credit back-pressure and a table write port
module rom_nport_stream import rom_stream_pkg::*; #(
  parameter int    DWIDTH     = 8,
  parameter int    AWIDTH     = 8,
  parameter int    MEM_SIZE   = 2**AWIDTH,
  parameter int    CHANNELS   = 2,
  parameter int    REG_ADDR   = 1,
  parameter int    FIFO_DEPTH = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*AWIDTH-1:0] rd_addr,
  input  logic [CHANNELS-1:0]        rd_valid,
  output logic [CHANNELS-1:0]        rd_ready,
  output logic [CHANNELS*DWIDTH-1:0] rd_data,
  output logic [CHANNELS-1:0]        rd_data_valid,
  input  logic [CHANNELS-1:0]        rd_data_ready,
  input  logic                       wr_en,
  input  logic [AWIDTH-1:0]          wr_addr,
  input  logic [DWIDTH-1:0]          wr_data
);
  localparam int              L   = rom_latency(REG_ADDR);
  localparam int              CW  = cnt_width(FIFO_DEPTH);
  localparam logic [AWIDTH:0] MSZ = (AWIDTH+1)'(MEM_SIZE);
  `ROM_STREAM_CHECK(g_chk_size, MEM_SIZE >= 1 && MEM_SIZE <= 2**AWIDTH)
  `ROM_STREAM_CHECK(g_chk_chan, CHANNELS >= 1)
  `ROM_STREAM_CHECK(g_chk_regaddr, REG_ADDR == 0 || REG_ADDR == 1)
  `ROM_STREAM_CHECK(g_chk_depth, FIFO_DEPTH >= 2 && is_pow2(FIFO_DEPTH))
  logic [DWIDTH-1:0] mem [MEM_SIZE];
  always_ff @(posedge clk)
    if (wr_en && {1'b0, wr_addr} < MSZ) mem[wr_addr] <= wr_data;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [AWIDTH-1:0] a;
    logic              av;
    logic [DWIDTH-1:0] m_data;
    logic              mv;
    logic [CW-1:0]     out_cnt;
    logic              req_hs, rsp_hs, f_valid;
    logic [DWIDTH-1:0] f_data;
    assign rd_ready[c] = rst_n & (out_cnt < CW'(FIFO_DEPTH));
    assign req_hs      = rd_valid[c] & rd_ready[c];
    assign rsp_hs      = f_valid & rd_data_ready[c];
    if (L == 2) begin : g_areg
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a  <= '0;
          av <= 1'b0;
        end else begin
          a  <= rd_addr[c*AWIDTH +: AWIDTH];
          av <= req_hs;
        end
    end else begin : g_acomb
      assign a  = rd_addr[c*AWIDTH +: AWIDTH];
      assign av = req_hs;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mv <= 1'b0;
      else mv <= av;
    always_ff @(posedge clk)
      m_data <= ({1'b0, a} < MSZ) ? mem[a] : '0;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) out_cnt <= '0;
      else out_cnt <= out_cnt + CW'(req_hs) - CW'(rsp_hs);
    rom_stream_fifo #(.DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (mv),
      .din   (m_data),
      .rd_en (rd_data_ready[c]),
      .dout  (f_data),
      .valid (f_valid)
    );
    assign rd_data[c*DWIDTH +: DWIDTH] = f_data;
    assign rd_data_valid[c]            = f_valid;
  end
endmodule

// File: tb/tb_rom_nport_stream.sv
// tb_rom_nport_stream: directed self-checking bench for rom_nport_stream
module tb_rom_nport_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rd_addr;
  logic [1:0]  rd_valid, rd_ready, rd_data_valid, rd_data_ready;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [7:0]  wr_addr, wr_data;
  logic [7:0]  s_rd_addr, s_rd_data;
  logic        s_rd_valid, s_rd_ready, s_rd_data_valid, s_rd_data_ready;
  int          checks = 0, failures = 0;
  int          acc, rx0, rx1, first0, bad, gaps, stalls, stale;
  logic [5:0]  rdy_hist;
  always #5 clk = ~clk;
  rom_nport_stream #(.DWIDTH(8), .AWIDTH(8), .MEM_SIZE(256), .CHANNELS(2), .REG_ADDR(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  rom_nport_stream #(.DWIDTH(8), .AWIDTH(8), .MEM_SIZE(200), .CHANNELS(1), .REG_ADDR(0), .FIFO_DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .rd_addr(s_rd_addr), .rd_valid(s_rd_valid), .rd_ready(s_rd_ready),
    .rd_data(s_rd_data), .rd_data_valid(s_rd_data_valid), .rd_data_ready(s_rd_data_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n === 1'b1)
      assert (u_dut.g_ch[0].u_fifo.cnt <= 3'd4 && u_dut.g_ch[1].u_fifo.cnt <= 3'd4) else begin
        failures++;
        $error("FAIL fifo_overflow observed=%0d/%0d expected<=4", u_dut.g_ch[0].u_fifo.cnt, u_dut.g_ch[1].u_fifo.cnt);
      end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    rst_n = 1'b0; rd_addr = '0; rd_valid = '0; rd_data_ready = 2'b11;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    s_rd_addr = '0; s_rd_valid = 1'b0; s_rd_data_ready = 1'b1;
    tick; tick;
    chk("reset_rd_ready", 32'(rd_ready), 32'h0);
    chk("reset_rd_data_valid", 32'(rd_data_valid), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_small_rd_ready", 32'(s_rd_ready), 32'h0);
    rst_n = 1'b1;
    tick;
    chk("release_rd_ready", 32'(rd_ready), 32'h3);
    chk("release_small_rd_ready", 32'(s_rd_ready), 32'h1);
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = 8'(i);
      tick;
    end
    wr_en = 1'b0;
    rd_addr[7:0] = 8'h05; rd_valid = 2'b01;
    tick;
    rd_valid = 2'b00;
    chk("single_k1_valid", 32'(rd_data_valid), 32'h0);
    tick;
    chk("single_k2_valid", 32'(rd_data_valid), 32'h0);
    tick;
    chk("single_k3_valid", 32'(rd_data_valid), 32'h1);
    chk("single_k3_data", 32'(rd_data), 32'h0005);
    tick;
    chk("single_drained", 32'(rd_data_valid), 32'h0);
    rd_data_ready = 2'b10; acc = 0;
    for (int i = 0; i < 6; i++) begin
      rd_addr[7:0] = 8'(8'h20 + acc); rd_valid[0] = 1'b1;
      rdy_hist[i] = rd_ready[0];
      if (rd_ready[0]) acc++;
      tick;
    end
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_ready_hist", 32'(rdy_hist), 32'h0f);
    chk("bp_ready_low", 32'(rd_ready[0]), 32'h0);
    rd_data_ready = 2'b11;
    chk("bp_a_valid", 32'(rd_data_valid[0]), 32'h1);
    chk("bp_a_data", 32'(rd_data[7:0]), 32'h20);
    tick;
    chk("bp_b_ready", 32'(rd_ready[0]), 32'h1);
    chk("bp_b_data", 32'(rd_data[7:0]), 32'h21);
    tick;
    rd_addr[7:0] = 8'h25;
    chk("bp_c_data", 32'(rd_data[7:0]), 32'h22);
    tick;
    rd_valid[0] = 1'b0;
    chk("bp_d_data", 32'(rd_data[7:0]), 32'h23);
    tick;
    chk("bp_e_valid", 32'(rd_data_valid[0]), 32'h1);
    chk("bp_e_data", 32'(rd_data[7:0]), 32'h24);
    tick;
    chk("bp_f_data", 32'(rd_data[7:0]), 32'h25);
    tick;
    chk("bp_drained", 32'(rd_data_valid), 32'h0);
    rx0 = 0; rx1 = 0; first0 = -1; bad = 0; gaps = 0; stalls = 0;
    for (int n = 0; n < 262; n++) begin
      if (n < 256) begin
        rd_valid = 2'b11; rd_addr = {8'(n), 8'(n)};
        if (rd_ready != 2'b11) stalls++;
      end else rd_valid = 2'b00;
      if (rd_data_valid[0]) begin
        if (first0 < 0) first0 = n;
        if (rd_data[7:0] != 8'(rx0)) bad++;
        rx0++;
      end else if (first0 >= 0 && rx0 < 256) gaps++;
      if (rd_data_valid[1]) begin
        if (rd_data[15:8] != 8'(rx1)) bad++;
        rx1++;
      end else if (rx1 > 0 && rx1 < 256) gaps++;
      tick;
    end
    chk("stream_first_cycle", 32'(first0), 32'd3);
    chk("stream_rx0", 32'(rx0), 32'd256);
    chk("stream_rx1", 32'(rx1), 32'd256);
    chk("stream_bad_data", 32'(bad), 32'd0);
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("stream_stalls", 32'(stalls), 32'd0);
    rd_addr[7:0] = 8'h10; rd_valid = 2'b01;
    tick;
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'hAA;
    tick;
    rd_valid = 2'b00; wr_en = 1'b0;
    tick;
    chk("coll_old_valid", 32'(rd_data_valid), 32'h1);
    chk("coll_old_data", 32'(rd_data[7:0]), 32'h10);
    tick;
    chk("coll_new_data", 32'(rd_data[7:0]), 32'hAA);
    tick;
    s_rd_addr = 8'd250; s_rd_valid = 1'b1;
    wr_en = 1'b1; wr_addr = 8'd250; wr_data = 8'h77;
    tick;
    wr_en = 1'b0; s_rd_addr = 8'd199;
    chk("small_k1_valid", 32'(s_rd_data_valid), 32'h0);
    tick;
    s_rd_addr = 8'd250;
    chk("small_oor_valid", 32'(s_rd_data_valid), 32'h1);
    chk("small_oor_data", 32'(s_rd_data), 32'h0);
    tick;
    s_rd_valid = 1'b0;
    chk("small_last_word", 32'(s_rd_data), 32'hC7);
    tick;
    chk("small_oor_after_write", 32'(s_rd_data), 32'h0);
    tick;
    rd_data_ready = 2'b00; rd_valid = 2'b01; rd_addr[7:0] = 8'h30;
    tick;
    rd_addr[7:0] = 8'h31;
    tick;
    rd_addr[7:0] = 8'h32;
    tick;
    rd_valid = 2'b00;
    chk("pre_reset_valid", 32'(rd_data_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_ready", 32'(rd_ready), 32'h0);
    chk("midrst_rd_data_valid", 32'(rd_data_valid), 32'h0);
    chk("midrst_rd_data", 32'(rd_data), 32'h0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("postrst_rd_ready", 32'(rd_ready), 32'h3);
    rd_data_ready = 2'b11; stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_data_valid != 2'b00) stale++;
      tick;
    end
    chk("postrst_stale", 32'(stale), 32'd0);
    rd_addr[7:0] = 8'h10; rd_valid = 2'b01;
    tick;
    rd_addr[7:0] = 8'h05;
    tick;
    rd_valid = 2'b00;
    tick;
    chk("retain_0x10", 32'(rd_data[7:0]), 32'hAA);
    tick;
    chk("retain_0x05", 32'(rd_data[7:0]), 32'h05);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
